// File: rtl/ct_ifu_btb_upd_buf_if.sv
// Bundles the BTB update request (from addrgen) and the BTB array write port.
// The slave modport is the buffer's view; master is the addrgen/BTB-array side.
interface ct_ifu_btb_upd_buf_if #(
   parameter int IDX_W = 10,
   parameter int TAG_W = 10,
   parameter int TGT_W = 20
);
   logic             addrgen_btb_update_vld;
   logic [IDX_W-1:0] addrgen_btb_index;
   logic [TAG_W-1:0] addrgen_btb_tag;
   logic [TGT_W-1:0] addrgen_btb_target_pc;
   logic             btb_updbuf_idle;
   logic             updbuf_btb_wr_vld;
   logic [IDX_W-1:0] updbuf_btb_wr_index;
   logic [TAG_W-1:0] updbuf_btb_wr_tag;
   logic [TGT_W-1:0] updbuf_btb_wr_target;

   modport master (
      output addrgen_btb_update_vld, addrgen_btb_index, addrgen_btb_tag,
             addrgen_btb_target_pc, btb_updbuf_idle,
      input  updbuf_btb_wr_vld, updbuf_btb_wr_index, updbuf_btb_wr_tag,
             updbuf_btb_wr_target
   );

   modport slave (
      input  addrgen_btb_update_vld, addrgen_btb_index, addrgen_btb_tag,
             addrgen_btb_target_pc, btb_updbuf_idle,
      output updbuf_btb_wr_vld, updbuf_btb_wr_index, updbuf_btb_wr_tag,
             updbuf_btb_wr_target
   );
endinterface

// File: rtl/ct_ifu_btb_upd_buf.sv
// BTB mispredict-correction update buffer: drop-oldest FIFO drained on BTB idle
// cycles, with starvation stall request. Optional in-place merge: CT_IFU_BTB_UPDBUF_MERGE_EN.
module ct_ifu_btb_upd_buf #(
   parameter int DEPTH     = 4,
   parameter int IDX_W     = 10,
   parameter int TAG_W     = 10,
   parameter int TGT_W     = 20,
   parameter int STARVE_TH = 15
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst_b,
   input  logic                 cp0_ifu_btb_en,
   input  logic                 btb_updbuf_inv_on,
   ct_ifu_btb_upd_buf_if.slave  upd,
   output logic                 updbuf_ifctrl_stall_req,
   output logic                 updbuf_hpcp_drop
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

   state_t           state;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [3:0]       age;
   logic             stall_q;
   logic             drop_q;

   logic [IDX_W-1:0] ent_idx [DEPTH];
   logic [TAG_W-1:0] ent_tag [DEPTH];
   logic [TGT_W-1:0] ent_tgt [DEPTH];

   logic flush, empty, full, enq, deq, merge, append, drop, head_chg;

   function automatic logic [3:0] age_sat_inc(input logic [3:0] a);
      if (a >= 4'(STARVE_TH)) return 4'(STARVE_TH);
      return a + 4'd1;
   endfunction

   assign flush    = !cp0_ifu_btb_en | btb_updbuf_inv_on;
   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign enq      = upd.addrgen_btb_update_vld & !flush;
   assign deq      = !empty & upd.btb_updbuf_idle & !flush;
   assign append   = enq & !merge;
   // A full buffer that is not draining this cycle sacrifices its head.
   assign drop     = full & append & !deq;
   assign head_chg = deq | drop;

`ifdef CT_IFU_BTB_UPDBUF_MERGE_EN
   logic [DEPTH-1:0] ent_vld;
   logic [DEPTH-1:0] match_vec;
   logic [PTR_W-1:0] match_ptr;

   // The head leaving this cycle cannot absorb a merge; the enq appends instead.
   always_comb begin
      match_vec = '0;
      match_ptr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = ent_vld[i]
                      && (ent_idx[i] == upd.addrgen_btb_index)
                      && (ent_tag[i] == upd.addrgen_btb_tag)
                      && !(deq && (PTR_W'(i) == rd_ptr));
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_vec[i]) match_ptr = PTR_W'(i);
      end
   end

   assign merge = enq & (|match_vec);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         ent_vld <= '0;
      end else if (flush) begin
         ent_vld <= '0;
      end else begin
         if (head_chg) ent_vld[rd_ptr] <= 1'b0;
         if (append)   ent_vld[wr_ptr] <= 1'b1;
      end
   end
`else
   assign merge = 1'b0;
`endif

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (append && !deq)
         count_nxt = full ? count : count + 1'b1;
      else if (!append && deq)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         age     <= '0;
         state   <= IDLE;
         stall_q <= 1'b0;
         drop_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_idx[i] <= '0;
            ent_tag[i] <= '0;
            ent_tgt[i] <= '0;
         end
      end else begin
         count  <= count_nxt;
         drop_q <= drop;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (head_chg) rd_ptr <= rd_ptr + 1'b1;
            if (append) begin
               wr_ptr          <= wr_ptr + 1'b1;
               ent_idx[wr_ptr] <= upd.addrgen_btb_index;
               ent_tag[wr_ptr] <= upd.addrgen_btb_tag;
               ent_tgt[wr_ptr] <= upd.addrgen_btb_target_pc;
            end
`ifdef CT_IFU_BTB_UPDBUF_MERGE_EN
            if (merge) ent_tgt[match_ptr] <= upd.addrgen_btb_target_pc;
`endif
         end

         if (flush || empty || head_chg)
            age <= '0;
         else
            age <= age_sat_inc(age);

         if (flush || (count_nxt == '0)) begin
            state   <= IDLE;
            stall_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= PEND;
                  stall_q <= 1'b0;
               end
               PEND: begin
                  if ((age == 4'(STARVE_TH)) && !head_chg) begin
                     state   <= FORCE;
                     stall_q <= 1'b1;
                  end
               end
               FORCE: begin
                  if (head_chg) begin
                     state   <= PEND;
                     stall_q <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  stall_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign upd.updbuf_btb_wr_vld    = deq;
   assign upd.updbuf_btb_wr_index  = ent_idx[rd_ptr];
   assign upd.updbuf_btb_wr_tag    = ent_tag[rd_ptr];
   assign upd.updbuf_btb_wr_target = ent_tgt[rd_ptr];
   assign updbuf_ifctrl_stall_req  = stall_q;
   assign updbuf_hpcp_drop         = drop_q;
endmodule

// File: tb/tb_ct_ifu_btb_upd_buf.sv
// Directed bench for ct_ifu_btb_upd_buf: ordering, overflow drop, starvation stall,
// flush, full enq+deq, and duplicate-key handling in both merge configurations.
module tb_ct_ifu_btb_upd_buf;
   logic forever_cpuclk = 1'b0;
   logic cpurst_b;
   logic cp0_ifu_btb_en;
   logic btb_updbuf_inv_on;
   logic updbuf_ifctrl_stall_req;
   logic updbuf_hpcp_drop;

   int total = 0;
   int bad   = 0;

   ct_ifu_btb_upd_buf_if #(.IDX_W(10), .TAG_W(10), .TGT_W(20)) upd_if ();

   ct_ifu_btb_upd_buf #(
      .DEPTH(4), .IDX_W(10), .TAG_W(10), .TGT_W(20), .STARVE_TH(15)
   ) dut (
      .forever_cpuclk          (forever_cpuclk),
      .cpurst_b                (cpurst_b),
      .cp0_ifu_btb_en          (cp0_ifu_btb_en),
      .btb_updbuf_inv_on       (btb_updbuf_inv_on),
      .upd                     (upd_if),
      .updbuf_ifctrl_stall_req (updbuf_ifctrl_stall_req),
      .updbuf_hpcp_drop        (updbuf_hpcp_drop)
   );

   always #5 forever_cpuclk = ~forever_cpuclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge forever_cpuclk);
      #1;
   endtask

   task automatic enq(input logic [9:0] idx, input logic [9:0] tag, input logic [19:0] tgt);
      upd_if.addrgen_btb_update_vld = 1'b1;
      upd_if.addrgen_btb_index      = idx;
      upd_if.addrgen_btb_tag        = tag;
      upd_if.addrgen_btb_target_pc  = tgt;
      tick();
      upd_if.addrgen_btb_update_vld = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [9:0] idx);
      chk({tag, "_vld"}, 32'(upd_if.updbuf_btb_wr_vld), 32'd1);
      chk({tag, "_idx"}, 32'(upd_if.updbuf_btb_wr_index), 32'(idx));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      cpurst_b                      = 1'b0;
      cp0_ifu_btb_en                = 1'b1;
      btb_updbuf_inv_on             = 1'b0;
      upd_if.btb_updbuf_idle        = 1'b0;
      upd_if.addrgen_btb_update_vld = 1'b0;
      upd_if.addrgen_btb_index      = '0;
      upd_if.addrgen_btb_tag        = '0;
      upd_if.addrgen_btb_target_pc  = '0;
      tick();
      tick();
      chk("rst_wr_vld", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      chk("rst_stall",  32'(updbuf_ifctrl_stall_req), 32'd0);
      chk("rst_drop",   32'(updbuf_hpcp_drop), 32'd0);
      chk("rst_wr_idx", 32'(upd_if.updbuf_btb_wr_index), 32'd0);
      cpurst_b = 1'b1;
      tick();

      // In-order drain of three queued updates
      enq(10'h010, 10'h011, 20'hA0010);
      enq(10'h020, 10'h021, 20'hA0020);
      enq(10'h030, 10'h031, 20'hA0030);
      #1;
      chk("ord_hold", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b1;
      #1;
      chk_wr("ord0", 10'h010);
      chk("ord0_tag", 32'(upd_if.updbuf_btb_wr_tag), 32'h011);
      chk("ord0_tgt", 32'(upd_if.updbuf_btb_wr_target), 32'hA0010);
      tick();
      chk_wr("ord1", 10'h020);
      chk("ord1_tgt", 32'(upd_if.updbuf_btb_wr_target), 32'hA0020);
      tick();
      chk_wr("ord2", 10'h030);
      tick();
      chk("ord_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      // Overflow: fifth enq into a full, stalled buffer drops the oldest
      for (int i = 1; i <= 4; i++) enq(10'(10'h100 + i), 10'h0AA, 20'(20'hB0000 + i));
      chk("ovf_nodrop4", 32'(updbuf_hpcp_drop), 32'd0);
      enq(10'h105, 10'h0AA, 20'hB0005);
      chk("ovf_drop", 32'(updbuf_hpcp_drop), 32'd1);
      tick();
      chk("ovf_drop_pulse", 32'(updbuf_hpcp_drop), 32'd0);
      upd_if.btb_updbuf_idle = 1'b1;
      #1;
      for (int i = 2; i <= 5; i++) begin
         chk_wr($sformatf("ovf_wr%0d", i), 10'(10'h100 + i));
         tick();
      end
      chk("ovf_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      // Starvation: head waits 16 cycles, stall request from the 17th
      enq(10'h200, 10'h201, 20'hC0200);
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("starve_c%0d", k), 32'(updbuf_ifctrl_stall_req), 32'd0);
         tick();
      end
      chk("starve_c17", 32'(updbuf_ifctrl_stall_req), 32'd1);
      upd_if.btb_updbuf_idle = 1'b1;
      #1;
      chk_wr("starve_wr", 10'h200);
      tick();
      chk("starve_release", 32'(updbuf_ifctrl_stall_req), 32'd0);
      chk("starve_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      // Flush with a coincident enq discards everything
      enq(10'h301, 10'h0BB, 20'hD0001);
      enq(10'h302, 10'h0BB, 20'hD0002);
      upd_if.addrgen_btb_update_vld = 1'b1;
      upd_if.addrgen_btb_index      = 10'h303;
      btb_updbuf_inv_on             = 1'b1;
      upd_if.btb_updbuf_idle        = 1'b1;
      #1;
      chk("flush_nowr", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      tick();
      upd_if.addrgen_btb_update_vld = 1'b0;
      btb_updbuf_inv_on             = 1'b0;
      #1;
      chk("flush_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      chk("flush_stall", 32'(updbuf_ifctrl_stall_req), 32'd0);
      tick();
      chk("flush_empty2", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      // Full buffer with simultaneous enq and deq: no drop, occupancy stays 4
      for (int i = 1; i <= 4; i++) enq(10'(10'h400 + i), 10'h0CC, 20'(20'hE0000 + i));
      upd_if.addrgen_btb_update_vld = 1'b1;
      upd_if.addrgen_btb_index      = 10'h405;
      upd_if.addrgen_btb_tag        = 10'h0CC;
      upd_if.addrgen_btb_target_pc  = 20'hE0005;
      upd_if.btb_updbuf_idle        = 1'b1;
      #1;
      chk_wr("fd_wr1", 10'h401);
      tick();
      upd_if.addrgen_btb_update_vld = 1'b0;
      #1;
      chk("fd_nodrop", 32'(updbuf_hpcp_drop), 32'd0);
      for (int i = 2; i <= 5; i++) begin
         chk_wr($sformatf("fd_wr%0d", i), 10'(10'h400 + i));
         tick();
      end
      chk("fd_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      // Same {index,tag} enqueued twice
      enq(10'h040, 10'h041, 20'h11111);
      enq(10'h040, 10'h041, 20'h22222);
      upd_if.btb_updbuf_idle = 1'b1;
      #1;
`ifdef CT_IFU_BTB_UPDBUF_MERGE_EN
      chk_wr("mrg_wr", 10'h040);
      chk("mrg_tgt", 32'(upd_if.updbuf_btb_wr_target), 32'h22222);
      tick();
      chk("mrg_single", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
`else
      chk_wr("dup_wr0", 10'h040);
      chk("dup_tgt0", 32'(upd_if.updbuf_btb_wr_target), 32'h11111);
      tick();
      chk_wr("dup_wr1", 10'h040);
      chk("dup_tgt1", 32'(upd_if.updbuf_btb_wr_target), 32'h22222);
      tick();
      chk("dup_empty", 32'(upd_if.updbuf_btb_wr_vld), 32'd0);
`endif
      upd_if.btb_updbuf_idle = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
